// File: rtl/gate_sequencer_if.sv
// Command and amplitude-RAM bundle for gate_sequencer.
// The slave modport is the sequencer's view. The master modport is the command source and RAM side.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

interface gate_sequencer_if #(
    parameter int unsigned NUM_QUBITS = 4,
    parameter int unsigned TGT_W      = 3,
    parameter int unsigned W          = `FIXED_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_gate;
    logic [TGT_W-1:0]      cmd_target;
    logic                  mem_re;
    logic                  mem_we;
    logic [NUM_QUBITS-1:0] mem_addr;
    logic signed [W-1:0]   mem_rdata_real;
    logic signed [W-1:0]   mem_rdata_imag;
    logic signed [W-1:0]   mem_wdata_real;
    logic signed [W-1:0]   mem_wdata_imag;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_gate, cmd_target, mem_rdata_real, mem_rdata_imag,
        input  cmd_ready, mem_re, mem_we, mem_addr, mem_wdata_real, mem_wdata_imag,
               busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_gate, cmd_target, mem_rdata_real, mem_rdata_imag,
        output cmd_ready, mem_re, mem_we, mem_addr, mem_wdata_real, mem_wdata_imag,
               busy, done, err
    );
endinterface

// File: rtl/gate_sequencer.sv
// Applies a single-qubit I/X/Y/Z gate to every amplitude pair of a state vector.
// The state vector lives in an external single-port sync-read RAM.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module gate_sequencer #(
    parameter int unsigned NUM_QUBITS = 4,
    parameter int unsigned TGT_W      = 3
) (
    input logic            clk,
    input logic            rst,
    gate_sequencer_if.slave bus
);
    localparam int unsigned W = `FIXED_WIDTH;
    localparam logic [NUM_QUBITS-1:0] LastPair = NUM_QUBITS'((1 << (NUM_QUBITS - 1)) - 1);

    typedef enum logic [2:0] {
        StIdle, StRd0, StRd1, StCap, StWr0, StWr1, StDone
    } state_t;

    state_t                state_q;
    logic [1:0]            gate_q;
    logic [TGT_W-1:0]      tgt_q;
    logic [NUM_QUBITS-1:0] pair_q;
    logic signed [W-1:0]   amp0_re_q, amp0_im_q, amp1_re_q, amp1_im_q;

    logic                  cmd_ready_q, busy_q, done_q, err_q;
    logic                  re_q, we_q;
    logic [NUM_QUBITS-1:0] addr_q;
    logic signed [W-1:0]   wd_re_q, wd_im_q;

    // Insert a zero at bit position t of the pair index.
    function automatic logic [NUM_QUBITS-1:0] pair_base(input logic [NUM_QUBITS-1:0] p,
                                                        input logic [TGT_W-1:0] t);
        logic [NUM_QUBITS-1:0] low_mask;
        logic [NUM_QUBITS-1:0] hi;
        low_mask = (NUM_QUBITS'(1) << t) - NUM_QUBITS'(1);
        hi       = ((p >> t) << 1) << t;
        return hi | (p & low_mask);
    endfunction

    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}}) begin
            return {1'b0, {(W-1){1'b1}}};
        end
        return -v;
    endfunction

    logic [NUM_QUBITS-1:0] a0, a1, a0_next, tgt_bit;
    logic signed [W-1:0]   r1, i1;
    logic signed [W-1:0]   n0_re, n0_im, n1_re, n1_im;
    logic                  oob;

    always_comb begin
        tgt_bit = NUM_QUBITS'(1) << tgt_q;
        a0      = pair_base(pair_q, tgt_q);
        a1      = a0 | tgt_bit;
        a0_next = pair_base(pair_q + NUM_QUBITS'(1), tgt_q);
        oob     = 32'(bus.cmd_target) >= NUM_QUBITS;
    end

    // In CAP the second amplitude is still on the read bus, so bypass the register.
    always_comb begin
        r1 = (state_q == StCap) ? bus.mem_rdata_real : amp1_re_q;
        i1 = (state_q == StCap) ? bus.mem_rdata_imag : amp1_im_q;
        n0_re = amp0_re_q;
        n0_im = amp0_im_q;
        n1_re = r1;
        n1_im = i1;
        case (gate_q)
            2'b01: begin
                n0_re = r1;
                n0_im = i1;
                n1_re = amp0_re_q;
                n1_im = amp0_im_q;
            end
            2'b10: begin
                n1_re = neg_sat(r1);
                n1_im = neg_sat(i1);
            end
            2'b11: begin
                n0_re = i1;
                n0_im = neg_sat(r1);
                n1_re = neg_sat(amp0_im_q);
                n1_im = amp0_re_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gate_q      <= 2'b00;
            tgt_q       <= '0;
            pair_q      <= '0;
            amp0_re_q   <= '0;
            amp0_im_q   <= '0;
            amp1_re_q   <= '0;
            amp1_im_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wd_re_q     <= '0;
            wd_im_q     <= '0;
        end else begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_re_q <= '0;
            wd_im_q <= '0;
            case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        gate_q      <= bus.cmd_gate;
                        tgt_q       <= bus.cmd_target;
                        pair_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (oob || bus.cmd_gate == 2'b00) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= oob;
                        end else begin
                            state_q <= StRd0;
                            re_q    <= 1'b1;
                            addr_q  <= pair_base('0, bus.cmd_target);
                        end
                    end
                end
                StRd0: begin
                    state_q <= StRd1;
                    re_q    <= 1'b1;
                    addr_q  <= a1;
                end
                StRd1: begin
                    amp0_re_q <= bus.mem_rdata_real;
                    amp0_im_q <= bus.mem_rdata_imag;
                    state_q   <= StCap;
                end
                StCap: begin
                    amp1_re_q <= bus.mem_rdata_real;
                    amp1_im_q <= bus.mem_rdata_imag;
                    state_q   <= StWr0;
                    we_q      <= 1'b1;
                    addr_q    <= a0;
                    wd_re_q   <= n0_re;
                    wd_im_q   <= n0_im;
                end
                StWr0: begin
                    state_q <= StWr1;
                    we_q    <= 1'b1;
                    addr_q  <= a1;
                    wd_re_q <= n1_re;
                    wd_im_q <= n1_im;
                end
                StWr1: begin
                    if (pair_q == LastPair) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        pair_q  <= pair_q + NUM_QUBITS'(1);
                        state_q <= StRd0;
                        re_q    <= 1'b1;
                        addr_q  <= a0_next;
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.mem_re         = re_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata_real = wd_re_q;
    assign bus.mem_wdata_imag = wd_im_q;
endmodule
